// File: rtl/display_scanner_if.sv
// Memory-read, buffer-swap and HUB75 panel signals of display_scanner.
// With DISPLAY_DIMMING_EN defined the interface also carries the brightness input.
interface display_scanner_if #(
    parameter int rows    = 8,
    parameter int columns = 32,
    parameter int width   = 24
);
    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns);

    logic [RW-1:0]    rrow;
    logic [CW-1:0]    rcol;
    logic [width-1:0] rdata;
    logic             flip;
    logic             swap_req;
    logic             swap_done;
    logic             panel_r;
    logic             panel_g;
    logic             panel_b;
    logic             panel_clk;
    logic             panel_lat;
    logic             panel_oe;
    logic [RW-1:0]    panel_row;
`ifdef DISPLAY_DIMMING_EN
    logic [7:0]       brightness;

    modport master (
        output rrow, rcol, flip, swap_done,
        output panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe, panel_row,
        input  rdata, swap_req, brightness
    );
    modport slave (
        input  rrow, rcol, flip, swap_done,
        input  panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe, panel_row,
        output rdata, swap_req, brightness
    );
`else
    modport master (
        output rrow, rcol, flip, swap_done,
        output panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe, panel_row,
        input  rdata, swap_req
    );
    modport slave (
        input  rrow, rcol, flip, swap_done,
        input  panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe, panel_row,
        output rdata, swap_req
    );
`endif
endinterface

// File: rtl/display_scanner.sv
// HUB75 row scanner with binary-coded modulation over a double-buffered display memory.
// DISPLAY_DIMMING_EN scales every OE window by an 8-bit brightness sampled at DISPLAY entry.
module display_scanner #(
    parameter int rows      = 8,
    parameter int columns   = 32,
    parameter int width     = 24,
    parameter int base_time = 4
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.master bus
);
    localparam int DEPTH = width / 3;
    localparam int RW    = $clog2(rows);
    localparam int CW    = $clog2(columns);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW    = $clog2((base_time << (DEPTH - 1)) + 1);

    typedef enum logic [2:0] {PRIME, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] prow_q, prow_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          flip_q, flip_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;

    logic [TW-1:0]    period;
    logic             last_tick;
    logic             frame_end;
    logic             oe_on;
    logic [DEPTH-1:0] fld_r, fld_g, fld_b;
    logic             pix_r, pix_g, pix_b;
    logic [CW-1:0]    rcol_c;
    logic             pclk_c, lat_c, oe_c, r_c, g_c, b_c;

    assign period    = TW'(base_time) << plane_q;
    assign last_tick = (timer_q == period - 1'b1);
    assign frame_end = (state_q == DISPLAY) && last_tick &&
                       (row_q == RW'(rows - 1)) && (plane_q == PW'(DEPTH - 1));

    assign fld_r = bus.rdata[2*DEPTH +: DEPTH];
    assign fld_g = bus.rdata[DEPTH +: DEPTH];
    assign fld_b = bus.rdata[0 +: DEPTH];
    assign pix_r = fld_r[plane_q];
    assign pix_g = fld_g[plane_q];
    assign pix_b = fld_b[plane_q];

`ifdef DISPLAY_DIMMING_EN
    logic [7:0]    bright_q;
    logic [TW+7:0] on_limit;

    // Brightness is captured on the edge that enters DISPLAY and held for the whole window.
    always_ff @(posedge clk) begin
        if (state_q == LATCH) begin
            bright_q <= bus.brightness;
        end
    end

    assign on_limit = ((TW+8)'(period) * (TW+8)'(bright_q)) >> 8;
    assign oe_on    = ((TW+8)'(timer_q) < on_limit);
`else
    assign oe_on = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        plane_d = plane_q;
        timer_d = timer_q;
        prow_d  = prow_q;
        flip_d  = flip_q;
        pend_d  = pend_q | bus.swap_req;
        done_d  = 1'b0;
        rcol_c  = '0;
        pclk_c  = 1'b0;
        lat_c   = 1'b0;
        oe_c    = 1'b1;
        r_c     = 1'b0;
        g_c     = 1'b0;
        b_c     = 1'b0;

        case (state_q)
            PRIME: begin
                col_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                rcol_c  = col_q;
                r_c     = pix_r;
                g_c     = pix_g;
                b_c     = pix_b;
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                // rdata still holds column col_q here; issue col_q+1 for the next SHIFT_LO.
                rcol_c  = col_q + 1'b1;
                pclk_c  = 1'b1;
                r_c     = pix_r;
                g_c     = pix_g;
                b_c     = pix_b;
                col_d   = col_q + 1'b1;
                state_d = (col_q == CW'(columns - 1)) ? LATCH : SHIFT_LO;
            end
            LATCH: begin
                lat_c   = 1'b1;
                prow_d  = row_q;
                timer_d = '0;
                state_d = DISPLAY;
            end
            DISPLAY: begin
                oe_c    = ~oe_on;
                timer_d = timer_q + 1'b1;
                if (last_tick) begin
                    state_d = PRIME;
                    if (plane_q == PW'(DEPTH - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end
            end
            default: state_d = PRIME;
        endcase

        // A request arriving in the frame-end cycle itself still takes this boundary.
        if (frame_end && pend_d) begin
            flip_d = ~flip_q;
            done_d = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRIME;
            row_q   <= '0;
            col_q   <= '0;
            plane_q <= '0;
            timer_q <= '0;
            prow_q  <= '0;
            flip_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            plane_q <= plane_d;
            timer_q <= timer_d;
            prow_q  <= prow_d;
            flip_q  <= flip_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign bus.rrow      = row_q;
    assign bus.rcol      = rcol_c;
    assign bus.flip      = flip_q;
    assign bus.swap_done = done_q;
    assign bus.panel_r   = r_c;
    assign bus.panel_g   = g_c;
    assign bus.panel_b   = b_c;
    assign bus.panel_clk = pclk_c;
    assign bus.panel_lat = lat_c;
    assign bus.panel_oe  = oe_c;
    assign bus.panel_row = prow_q;
endmodule
